// File: rtl/dispense_control.sv
// Feeder dispense controller: latches a BCD limit on enable rise, runs the motor and counts food pulses.
// Optional jam-retry (one reverse pulse before declaring a jam) is built when JAM_RETRY_EN is defined.
module dispense_control #(
    parameter int TMO_W      = 26,
    parameter int TMO_CYCLES = 50_000_000
`ifdef JAM_RETRY_EN
    ,
    parameter int REV_CYCLES = 25_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] limite,
    input  logic       food_pulse,
    output logic       motor,
    output logic       motor_rev,
    output logic       busy,
    output logic       done,
    output logic       jam,
    output logic [7:0] count
);

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_CYCLES - 1);
`ifdef JAM_RETRY_EN
    localparam logic [TMO_W-1:0] REV_MAX = TMO_W'(REV_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_JAM
`ifdef JAM_RETRY_EN
        ,
        ST_REV
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       limit_q, limit_d;
    logic [7:0]       count_q, count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync3_q, sync3_d;
    logic             enable_q, enable_d;
    logic             enable_low_seen_q, enable_low_seen_d;
`ifdef JAM_RETRY_EN
    logic [TMO_W-1:0] rev_q, rev_d;
    logic             retried_q, retried_d;
`endif

    logic       pulse;
    logic       start;
    logic       tmo_expired;
    logic       bad_digit;
    logic [7:0] count_inc;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            limit_q           <= 8'h00;
            count_q           <= 8'h00;
            tmo_q             <= '0;
            sync1_q           <= 1'b0;
            sync2_q           <= 1'b0;
            sync3_q           <= 1'b0;
            enable_q          <= 1'b0;
            enable_low_seen_q <= 1'b0;
`ifdef JAM_RETRY_EN
            rev_q             <= '0;
            retried_q         <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            limit_q           <= limit_d;
            count_q           <= count_d;
            tmo_q             <= tmo_d;
            sync1_q           <= sync1_d;
            sync2_q           <= sync2_d;
            sync3_q           <= sync3_d;
            enable_q          <= enable_d;
            enable_low_seen_q <= enable_low_seen_d;
`ifdef JAM_RETRY_EN
            rev_q             <= rev_d;
            retried_q         <= retried_d;
`endif
        end
    end

    // A start also needs enable to have been seen low since reset, so a reset
    // while enable is still high never relaunches the run.
    always_comb begin
        sync1_d           = food_pulse;
        sync2_d           = sync1_q;
        sync3_d           = sync2_q;
        enable_d          = enable;
        enable_low_seen_d = enable_low_seen_q | ~enable;
        pulse             = sync2_q & ~sync3_q;
        start             = enable & ~enable_q & enable_low_seen_q;
        tmo_expired       = (tmo_q == TMO_MAX);
        bad_digit         = (limite[7:4] > 4'd9) || (limite[3:0] > 4'd9);
        count_inc         = bcd_inc(count_q);
    end

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        count_d   = count_q;
        tmo_d     = tmo_q;
`ifdef JAM_RETRY_EN
        rev_d     = rev_q;
        retried_d = retried_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    limit_d = limite;
                    count_d = 8'h00;
                    tmo_d   = '0;
`ifdef JAM_RETRY_EN
                    retried_d = 1'b0;
`endif
                    if (bad_digit) begin
                        state_d = ST_JAM;
                    end else if (limite == 8'h00) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            // Priority: abort, then pulse (which beats a same-cycle timeout), then timeout.
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (pulse) begin
                    count_d = count_inc;
                    tmo_d   = '0;
                    if (count_inc == limit_q) begin
                        state_d = ST_DONE;
                    end
                end else if (tmo_expired) begin
`ifdef JAM_RETRY_EN
                    if (!retried_q) begin
                        state_d   = ST_REV;
                        rev_d     = '0;
                        retried_d = 1'b1;
                    end else begin
                        state_d = ST_JAM;
                    end
`else
                    state_d = ST_JAM;
`endif
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`ifdef JAM_RETRY_EN
            ST_REV: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (rev_q == REV_MAX) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else begin
                    rev_d = rev_q + TMO_W'(1);
                end
            end
`endif
            ST_DONE, ST_JAM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        motor = (state_q == ST_RUN);
        done  = (state_q == ST_DONE);
        jam   = (state_q == ST_JAM);
        count = count_q;
`ifdef JAM_RETRY_EN
        motor_rev = (state_q == ST_REV);
        busy      = (state_q == ST_RUN) || (state_q == ST_REV);
`else
        motor_rev = 1'b0;
        busy      = (state_q == ST_RUN);
`endif
    end

endmodule

// File: tb/tb_dispense_control.sv
// Directed self-checking bench for dispense_control, built with TMO_CYCLES=20 (REV_CYCLES=8 when JAM_RETRY_EN).
module tb_dispense_control;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] limite;
    logic       food_pulse;
    logic       motor;
    logic       motor_rev;
    logic       busy;
    logic       done;
    logic       jam;
    logic [7:0] count;

    int checkCount;
    int errorCount;

    dispense_control #(
        .TMO_W      (26),
        .TMO_CYCLES (20)
`ifdef JAM_RETRY_EN
        ,
        .REV_CYCLES (8)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .limite     (limite),
        .food_pulse (food_pulse),
        .motor      (motor),
        .motor_rev  (motor_rev),
        .busy       (busy),
        .done       (done),
        .jam        (jam),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] lim, input int cycles);
        enable = en;
        limite = lim;
        step(cycles);
    endtask

    // One-cycle sensor pulse; returns right after the edge that registers the count.
    task automatic sendPulse();
        food_pulse = 1'b1;
        step(1);
        food_pulse = 1'b0;
        step(2);
    endtask

    function automatic logic [7:0] toBcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        limite     = 8'h00;
        food_pulse = 1'b0;
        step(3);
        checkOutput("rst_motor", {7'd0, motor}, 8'h00);
        checkOutput("rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("rst_done", {7'd0, done}, 8'h00);
        checkOutput("rst_jam", {7'd0, jam}, 8'h00);
        checkOutput("rst_count", count, 8'h00);
        checkOutput("rst_rev", {7'd0, motor_rev}, 8'h00);
        reset = 1'b0;
        step(2);

        // Limit 12: count through the units carry, stop exactly on 12.
        applyStimulus(1'b1, 8'h12, 1);
        checkOutput("run12_motor", {7'd0, motor}, 8'h01);
        checkOutput("run12_busy", {7'd0, busy}, 8'h01);
        checkOutput("run12_count0", count, 8'h00);
        limite = 8'h03;
        for (int i = 0; i < 12; i++) begin
            sendPulse();
            checkOutput("run12_count", count, toBcd(i + 1));
            checkOutput("run12_motor_step", {7'd0, motor}, (i < 11) ? 8'h01 : 8'h00);
            step(2);
        end
        checkOutput("run12_done", {7'd0, done}, 8'h01);
        step(3);
        checkOutput("done_hold_motor", {7'd0, motor}, 8'h00);
        checkOutput("done_hold_done", {7'd0, done}, 8'h01);
        applyStimulus(1'b0, 8'h03, 1);
        checkOutput("done_exit", {7'd0, done}, 8'h00);
        checkOutput("done_exit_count", count, 8'h12);

        // Zero limit finishes immediately without running the motor.
        applyStimulus(1'b1, 8'h00, 1);
        checkOutput("zero_done", {7'd0, done}, 8'h01);
        checkOutput("zero_motor", {7'd0, motor}, 8'h00);
        checkOutput("zero_count", count, 8'h00);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("zero_exit", {7'd0, done}, 8'h00);

        // Invalid BCD digit jams on the start edge.
        applyStimulus(1'b1, 8'h1A, 1);
        checkOutput("bad_jam", {7'd0, jam}, 8'h01);
        checkOutput("bad_motor", {7'd0, motor}, 8'h00);
        step(3);
        checkOutput("bad_jam_hold", {7'd0, jam}, 8'h01);
        applyStimulus(1'b0, 8'h1A, 1);
        checkOutput("bad_exit", {7'd0, jam}, 8'h00);

        // Pulses stop after two: timeout.
        applyStimulus(1'b1, 8'h05, 1);
        sendPulse();
        step(2);
        sendPulse();
        checkOutput("tmo_count", count, 8'h02);
        step(15);
        checkOutput("tmo_early_motor", {7'd0, motor}, 8'h01);
        checkOutput("tmo_early_jam", {7'd0, jam}, 8'h00);
`ifdef JAM_RETRY_EN
        step(7);
        checkOutput("rev_motor_rev", {7'd0, motor_rev}, 8'h01);
        checkOutput("rev_motor", {7'd0, motor}, 8'h00);
        checkOutput("rev_busy", {7'd0, busy}, 8'h01);
        step(9);
        checkOutput("rev_back_motor", {7'd0, motor}, 8'h01);
        checkOutput("rev_back_rev", {7'd0, motor_rev}, 8'h00);
        step(25);
`else
        step(10);
`endif
        checkOutput("tmo_jam", {7'd0, jam}, 8'h01);
        checkOutput("tmo_motor", {7'd0, motor}, 8'h00);
        checkOutput("tmo_jam_count", count, 8'h02);
        applyStimulus(1'b0, 8'h05, 1);
        checkOutput("tmo_exit", {7'd0, jam}, 8'h00);

        // Abort in the same cycle as a pulse edge: count must not move.
        applyStimulus(1'b1, 8'h09, 1);
        for (int i = 0; i < 3; i++) begin
            sendPulse();
            step(2);
        end
        checkOutput("abort_pre_count", count, 8'h03);
        food_pulse = 1'b1;
        step(1);
        food_pulse = 1'b0;
        step(1);
        enable = 1'b0;
        step(1);
        checkOutput("abort_count", count, 8'h03);
        checkOutput("abort_motor", {7'd0, motor}, 8'h00);
        checkOutput("abort_busy", {7'd0, busy}, 8'h00);
        step(3);
        checkOutput("abort_count_hold", count, 8'h03);

        // Reset mid-run; enable held high must not restart.
        applyStimulus(1'b1, 8'h09, 1);
        for (int i = 0; i < 7; i++) begin
            sendPulse();
            step(1);
        end
        checkOutput("mid_count", count, 8'h07);
        checkOutput("mid_motor", {7'd0, motor}, 8'h01);
        reset = 1'b1;
        step(1);
        checkOutput("mid_rst_motor", {7'd0, motor}, 8'h00);
        checkOutput("mid_rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("mid_rst_count", count, 8'h00);
        reset = 1'b0;
        step(4);
        checkOutput("mid_norestart_motor", {7'd0, motor}, 8'h00);
        checkOutput("mid_norestart_busy", {7'd0, busy}, 8'h00);
        applyStimulus(1'b0, 8'h09, 2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
